lock_alarm_controller: RTL and testbench



---
 rtl/lock_pkg.sv | 24 ++
 rtl/lock_alarm_controller_hex.sv | 13 +
 rtl/lock_alarm_controller.sv | 150 +++++++++++++++
 tb/tb_lock_alarm_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared encodings for the combination-lock state bus, the alarm
// controller's internal states and the seven-segment glyphs (active-low,
// bit6=a .. bit0=g).
package lock_pkg;
    localparam logic [2:0] LS_INERT       = 3'b000;
    localparam logic [2:0] LS_CHECK_ALARM = 3'b001;
    localparam logic [2:0] LS_OPEN        = 3'b010;
    localparam logic [2:0] LS_ALARM       = 3'b011;
    localparam logic [2:0] LS_CHANGE      = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RELEASE,
        ST_ALARMING,
        ST_LOCKOUT
    } ctrl_state_t;

    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_L    = 7'b1110001;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
endpackage

// File: rtl/lock_alarm_controller_hex.sv
// hex_digit_decoder: combinational glyph select for the HEX4 display.
//   i_value   : failure count to show (0..9; larger values show '-')
//   i_lockout : when high, show 'L' regardless of i_value
//   o_seg     : active-low segments, bit6=a .. bit0=g
module hex_digit_decoder
    import lock_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_lockout,
    output logic [6:0] o_seg
);
    assign o_seg = i_lockout ? SEG_L : (i_value <= 4'd9 ? SEG_DIGIT[i_value] : SEG_DASH);
endmodule

// File: rtl/lock_alarm_controller.sv
// lock_alarm_controller: turns lock-FSM state entries into door release,
// alarm buzzer, failed-attempt counting with timed lockout and the HEX4 digit.
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   lock_state   : lock FSM state bus (lock_pkg LS_* encodings)
//   door_release : door solenoid strobe, OPEN_CYCLES long per OPEN entry
//   buzzer       : square wave with BLINK_HALF-cycle half-period while alarming
//   lockout      : high for LOCKOUT_CYCLES after the MAX_FAILS-th failure
//   fail_count   : failures since last success or lockout expiry
//   HEX4         : active-low segments showing fail_count or 'L'
module lock_alarm_controller
    import lock_pkg::*;
#(
    parameter int unsigned OPEN_CYCLES    = 50000000,
    parameter int unsigned BLINK_HALF     = 12500000,
    parameter int unsigned LOCKOUT_CYCLES = 250000000,
    parameter int unsigned MAX_FAILS      = 3
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] lock_state,
    output logic       door_release,
    output logic       buzzer,
    output logic       lockout,
    output logic [3:0] fail_count,
    output logic [6:0] HEX4
);
    localparam int unsigned MAX_OB = OPEN_CYCLES > BLINK_HALF ? OPEN_CYCLES : BLINK_HALF;
    localparam int unsigned MAX_P  = MAX_OB > LOCKOUT_CYCLES ? MAX_OB : LOCKOUT_CYCLES;
    localparam int unsigned TW     = $clog2(MAX_P) + 1;
    localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] BLINK_LD = TW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAILS);

    ctrl_state_t   r_state, w_state_nx;
    logic [2:0]    r_prev;
    logic [TW-1:0] r_timer, w_timer_nx, r_blink, w_blink_nx, w_blink_step;
    logic          r_door, w_door_nx, r_buzz, w_buzz_nx, w_buzz_step, r_lock, w_lock_nx;
    logic [3:0]    r_fail, w_fail_nx, w_fail_inc;
    logic [6:0]    r_hex, w_hex_nx;
    logic          w_open_in, w_alarm_in, w_timer_zero;

    assign w_open_in    = lock_state == LS_OPEN && r_prev != LS_OPEN;
    assign w_alarm_in   = lock_state == LS_ALARM && r_prev != LS_ALARM;
    assign w_timer_zero = r_timer == '0;
    assign w_fail_inc   = r_fail == FAIL_MAX ? r_fail : r_fail + 4'd1;
    // One buzzer half-period step: toggle and reload when the blink timer runs out.
    assign w_blink_step = r_blink == '0 ? BLINK_LD : r_blink - 1'b1;
    assign w_buzz_step  = r_blink == '0 ? ~r_buzz : r_buzz;

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_blink_nx = r_blink;
        w_door_nx  = r_door;
        w_buzz_nx  = r_buzz;
        w_lock_nx  = r_lock;
        w_fail_nx  = r_fail;
        unique case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (w_alarm_in) begin
                    w_state_nx = ST_ALARMING;
                    w_door_nx  = 1'b0;
                    w_buzz_nx  = 1'b1;
                    w_blink_nx = BLINK_LD;
                    w_fail_nx  = w_fail_inc;
                end else if (w_open_in) begin
                    w_state_nx = ST_RELEASE;
                    w_door_nx  = 1'b1;
                    w_timer_nx = OPEN_LD;
                    w_fail_nx  = 4'd0;
                end else if (r_state == ST_RELEASE) begin
                    w_state_nx = w_timer_zero ? ST_IDLE : ST_RELEASE;
                    w_door_nx  = !w_timer_zero;
                    w_timer_nx = w_timer_zero ? r_timer : r_timer - 1'b1;
                end
            end
            ST_ALARMING: begin
                if (lock_state != LS_ALARM) begin
                    w_buzz_nx  = 1'b0;
                    w_state_nx = r_fail == FAIL_MAX ? ST_LOCKOUT : ST_IDLE;
                    w_lock_nx  = r_fail == FAIL_MAX;
                    w_timer_nx = LOCK_LD;
                end else begin
                    w_buzz_nx  = w_buzz_step;
                    w_blink_nx = w_blink_step;
                end
            end
            ST_LOCKOUT: begin
                if (w_timer_zero) begin
                    w_state_nx = ST_IDLE;
                    w_lock_nx  = 1'b0;
                    w_fail_nx  = 4'd0;
                    w_buzz_nx  = 1'b0;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                    // Lockout is entered on an edge where lock_state is not ALARM,
                    // so any ALARM seen here started with an entry inside lockout.
                    if (w_alarm_in) begin
                        w_buzz_nx  = 1'b1;
                        w_blink_nx = BLINK_LD;
                    end else if (lock_state == LS_ALARM) begin
                        w_buzz_nx  = w_buzz_step;
                        w_blink_nx = w_blink_step;
                    end else begin
                        w_buzz_nx  = 1'b0;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    hex_digit_decoder u_hex (
        .i_value   (w_fail_nx),
        .i_lockout (w_lock_nx),
        .o_seg     (w_hex_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_prev  <= LS_INERT;
            r_timer <= '0;
            r_blink <= '0;
            r_door  <= 1'b0;
            r_buzz  <= 1'b0;
            r_lock  <= 1'b0;
            r_fail  <= 4'd0;
            r_hex   <= SEG_DIGIT[0];
        end else begin
            r_state <= w_state_nx;
            r_prev  <= lock_state;
            r_timer <= w_timer_nx;
            r_blink <= w_blink_nx;
            r_door  <= w_door_nx;
            r_buzz  <= w_buzz_nx;
            r_lock  <= w_lock_nx;
            r_fail  <= w_fail_nx;
            r_hex   <= w_hex_nx;
        end
    end

    assign door_release = r_door;
    assign buzzer       = r_buzz;
    assign lockout      = r_lock;
    assign fail_count   = r_fail;
    assign HEX4         = r_hex;
endmodule

// File: tb/tb_lock_alarm_controller.sv
// tb_lock_alarm_controller: directed plus randomized lock_state stimulus; a
// count-based reference model pushes expected outputs into a queue that a
// separate monitor pops and compares one time unit after every clock edge.
module tb_lock_alarm_controller;
    localparam int OPEN_C = 8;
    localparam int BLINK  = 3;
    localparam int LOCK_C = 20;
    localparam int MAXF   = 3;
    localparam logic [2:0] S_INERT = 3'b000, S_CHK = 3'b001, S_OPEN = 3'b010,
                           S_ALARM = 3'b011, S_CHG = 3'b101;

    typedef struct packed {
        logic       door;
        logic       buzz;
        logic       lock;
        logic [3:0] fail;
        logic [6:0] hex;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] lock_state = S_INERT;
    logic       door_release, buzzer, lockout;
    logic [3:0] fail_count;
    logic [6:0] HEX4;

    int n_checks = 0;
    int n_pass   = 0;
    obs_t exp_q[$];

    logic [6:0] digit_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    // Reference model: remaining strobe cycles, remaining lockout cycles and
    // age of the current alarm episode (-1 when no alarm is sounding).
    int         m_door_left, m_lock_left, m_alarm_age, m_fail;
    logic [2:0] m_prev;

    lock_alarm_controller #(
        .OPEN_CYCLES(OPEN_C), .BLINK_HALF(BLINK), .LOCKOUT_CYCLES(LOCK_C), .MAX_FAILS(MAXF)
    ) dut (
        .clk(clk), .reset(reset), .lock_state(lock_state),
        .door_release(door_release), .buzzer(buzzer), .lockout(lockout),
        .fail_count(fail_count), .HEX4(HEX4)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        o.door = m_door_left > 0;
        o.buzz = m_alarm_age >= 0 && ((m_alarm_age / BLINK) % 2 == 0);
        o.lock = m_lock_left > 0;
        o.fail = 4'(m_fail);
        o.hex  = o.lock ? 7'b1110001 : digit_tab[m_fail];
        return o;
    endfunction

    function automatic void model_reset();
        m_door_left = 0;
        m_lock_left = 0;
        m_alarm_age = -1;
        m_fail      = 0;
        m_prev      = S_INERT;
    endfunction

    function automatic void model_step(input logic [2:0] ls);
        bit open_in, alarm_in;
        open_in  = ls == S_OPEN && m_prev != S_OPEN;
        alarm_in = ls == S_ALARM && m_prev != S_ALARM;
        m_prev   = ls;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fail      = 0;
                m_alarm_age = -1;
            end else if (alarm_in) m_alarm_age = 0;
            else if (ls == S_ALARM && m_alarm_age >= 0) m_alarm_age++;
            else m_alarm_age = -1;
        end else if (m_alarm_age >= 0) begin
            if (ls != S_ALARM) begin
                m_alarm_age = -1;
                if (m_fail == MAXF) m_lock_left = LOCK_C;
            end else m_alarm_age++;
        end else if (alarm_in) begin
            m_door_left = 0;
            m_alarm_age = 0;
            m_fail      = m_fail < MAXF ? m_fail + 1 : MAXF;
        end else if (open_in) begin
            m_door_left = OPEN_C;
            m_fail      = 0;
        end else if (m_door_left > 0) m_door_left--;
    endfunction

    function automatic void check(input obs_t e, input string name);
        obs_t g;
        g = '{door_release, buzzer, lockout, fail_count, HEX4};
        n_checks++;
        if (g === e) n_pass++;
        else $display("FAIL %s @%0t: got door=%b buzz=%b lock=%b fail=%0d hex=%b, expected door=%b buzz=%b lock=%b fail=%0d hex=%b",
                      name, $time, g.door, g.buzz, g.lock, g.fail, g.hex,
                      e.door, e.buzz, e.lock, e.fail, e.hex);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check(exp_q.pop_front(), "edge");
    end

    task automatic edge_step();
        @(posedge clk);
        model_step(lock_state);
        exp_q.push_back(model_obs());
    endtask

    task automatic step(input logic [2:0] ls, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lock_state = ls;
            edge_step();
        end
    endtask

    // Assert reset between edges, check the outputs cleared without a clock
    // edge, then release on a falling edge and model the next rising edge.
    task automatic async_reset(input int hold);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check(model_obs(), "async_reset");
        repeat (hold) @(negedge clk);
        reset = 1'b1;
        edge_step();
    endtask

    task automatic alarm_episodes(input int n);
        for (int i = 0; i < n; i++) begin
            step(S_ALARM, 4);
            step(S_INERT, 2);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check(model_obs(), "reset_hold");
        reset = 1'b1;
        edge_step();
        step(S_INERT, 5);
        step(S_CHK, 3);
        step(S_CHG, 3);
        step(S_INERT, 2);
        // Door strobe with a retrigger four edges after entry.
        step(S_OPEN, 3);
        step(S_INERT, 1);
        step(S_OPEN, 1);
        step(S_INERT, 12);
        // Buzzer pattern over a 12-cycle alarm.
        step(S_ALARM, 12);
        step(S_INERT, 3);
        // Clear count, then three failures into lockout; OPEN and ALARM inside it.
        step(S_OPEN, 1);
        step(S_INERT, 10);
        alarm_episodes(3);
        step(S_OPEN, 2);
        step(S_INERT, 2);
        step(S_ALARM, 5);
        step(S_INERT, 15);
        // Two failures, then success clears the count.
        alarm_episodes(2);
        step(S_OPEN, 1);
        step(S_INERT, 10);
        // Alarm aborts a running strobe.
        step(S_OPEN, 1);
        step(S_INERT, 2);
        step(S_ALARM, 3);
        step(S_INERT, 3);
        // Reset in the middle of lockout with the buzzer sounding.
        step(S_OPEN, 1);
        step(S_INERT, 9);
        alarm_episodes(3);
        step(S_INERT, 6);
        step(S_ALARM, 2);
        async_reset(2);
        step(S_OPEN, 1);
        step(S_INERT, 10);
        for (int s = 0; s < 300; s++) begin
            int r;
            logic [2:0] ls;
            r  = $urandom_range(0, 9);
            ls = r < 3 ? S_INERT : r == 3 ? S_CHK : r == 4 ? S_CHG : r < 7 ? S_OPEN : S_ALARM;
            if ($urandom_range(0, 49) == 0) async_reset($urandom_range(1, 3));
            step(ls, $urandom_range(1, 12));
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
